// File: rtl/div_pkg.sv
// Shared types and constants for the sequential divider.
//   div_state_t : controller state encoding (IDLE, RUN, DONE)
//   DIV_N       : default operand width
package div_pkg;

  localparam int DIV_N = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } div_state_t;

endpackage

// File: rtl/div_step.sv
// One restoring-division step (purely combinational).
//   rem      : current partial remainder (N bits, always < divisor)
//   qsh      : quotient shift register; its MSB is the next dividend bit
//   divisor  : non-zero divisor
//   rem_nxt  : partial remainder after this step
//   qsh_nxt  : qsh shifted left with the new quotient bit in bit 0
module div_step #(
  parameter int N = 4
) (
  input  logic [N-1:0] rem,
  input  logic [N-1:0] qsh,
  input  logic [N-1:0] divisor,
  output logic [N-1:0] rem_nxt,
  output logic [N-1:0] qsh_nxt
);

  logic [N:0] trial;
  logic       fits;

  always_comb begin
    trial = {rem, qsh[N-1]};
    fits  = (trial >= {1'b0, divisor});
    // When the divisor fits, the true difference is < divisor < 2^N, so the
    // low N bits of the modulo-2^N subtraction are exact.
    if (fits) begin
      rem_nxt = trial[N-1:0] - divisor;
    end else begin
      rem_nxt = trial[N-1:0];
    end
    qsh_nxt = {qsh[N-2:0], fits};
  end

endmodule

// File: rtl/seq_div.sv
// Sequential unsigned N-bit restoring divider, one quotient bit per clock.
//   clk, rst_n  : clock, asynchronous active-low reset
//   start       : division request, honoured only in IDLE
//   A, B        : dividend / divisor, sampled on the accepting edge
//   Q, R        : quotient / remainder, held until the next accepted start
//   busy        : high in RUN and DONE
//   done        : one-cycle result-valid pulse
//   div_by_zero : set with the result when B was 0
//   dbg_state   : current controller state
//
// Handshake: a request is taken on a rising edge where state is IDLE and
// start=1; start is ignored otherwise (no queuing). The result is valid in
// the single cycle where done=1 and stays on Q/R/div_by_zero afterwards.
module seq_div
  import div_pkg::*;
#(
  parameter int N = DIV_N
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  output logic [N-1:0] Q,
  output logic [N-1:0] R,
  output logic         busy,
  output logic         done,
  output logic         div_by_zero,
  output div_state_t   dbg_state
);

  localparam int CW = (N > 2) ? $clog2(N) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

  div_state_t    state, state_nxt;
  logic [N-1:0]  rem, qsh, divisor;
  logic [CW-1:0] count;
  logic [N-1:0]  step_rem, step_qsh;

  div_step #(.N(N)) u_step (
    .rem     (rem),
    .qsh     (qsh),
    .divisor (divisor),
    .rem_nxt (step_rem),
    .qsh_nxt (step_qsh)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and status outputs
  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = (B != '0) ? RUN : DONE;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (count == '0) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        busy      = 1'b1;
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Datapath and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem         <= '0;
      qsh         <= '0;
      divisor     <= '0;
      count       <= '0;
      Q           <= '0;
      R           <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            if (B != '0) begin
              qsh     <= A;
              divisor <= B;
              rem     <= '0;
              count   <= CNT_LAST;
            end else begin
              // Division by zero skips RUN and reports all-ones / dividend.
              Q           <= '1;
              R           <= A;
              div_by_zero <= 1'b1;
            end
          end
        end
        RUN: begin
          rem   <= step_rem;
          qsh   <= step_qsh;
          count <= count - 1'b1;
          if (count == '0) begin
            Q           <= step_qsh;
            R           <= step_rem;
            div_by_zero <= 1'b0;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign dbg_state = state;

endmodule

// File: tb/tb_seq_div.sv
module tb_seq_div;
  import div_pkg::*;

  localparam int N = 4;
  localparam int MAXV = (1 << N) - 1;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [N-1:0] A = '0;
  logic [N-1:0] B = '0;
  logic [N-1:0] Q, R;
  logic         busy, done, div_by_zero;
  div_state_t   dbg_state;

  int checks = 0;
  int failures = 0;

  seq_div #(.N(N)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .A           (A),
    .B           (B),
    .Q           (Q),
    .R           (R),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero),
    .dbg_state   (dbg_state)
  );

  // Clock
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Issue one division and check the whole transaction against plain
  // arithmetic. With hold=1, start stays high after acceptance and A/B move
  // to ha/hb, which must not disturb the running division.
  task automatic run_div(input int a, input int b, input bit hold,
                         input int ha, input int hb);
    int  exp_q, exp_r, exp_lat, lat;
    bit  seen, busy_ok;
    string id;
    id      = $sformatf("a=%0d b=%0d", a, b);
    exp_q   = (b == 0) ? MAXV : a / b;
    exp_r   = (b == 0) ? a : a % b;
    exp_lat = (b == 0) ? 1 : N + 1;
    seen    = 0;
    busy_ok = 1;
    lat     = 0;
    @(negedge clk);
    A = N'(a);
    B = N'(b);
    start = 1'b1;
    for (int e = 1; e <= 20; e++) begin
      @(posedge clk);
      #1;
      lat = e;
      if (e == 1) begin
        if (hold) begin
          A = N'(ha);
          B = N'(hb);
        end else begin
          start = 1'b0;
          A = N'($urandom_range(0, MAXV));
          B = N'($urandom_range(0, MAXV));
        end
      end
      if (busy !== 1'b1) busy_ok = 0;
      if (done === 1'b1) begin
        seen = 1;
        break;
      end
    end
    chk({"done_seen ", id}, 32'(seen), 1);
    chk({"latency ", id}, lat, exp_lat);
    chk({"busy_during ", id}, 32'(busy_ok), 1);
    chk({"q ", id}, 32'(Q), exp_q);
    chk({"r ", id}, 32'(R), exp_r);
    chk({"dbz ", id}, 32'(div_by_zero), (b == 0) ? 1 : 0);
    if (b != 0) chk({"qb_plus_r ", id}, 32'(Q) * b + 32'(R), a);
    // Pulse ends, back to IDLE with the result held.
    @(posedge clk);
    #1;
    chk({"done_pulse ", id}, 32'(done), 0);
    chk({"busy_idle ", id}, 32'(busy), 0);
    chk({"q_hold ", id}, 32'(Q), exp_q);
    chk({"r_hold ", id}, 32'(R), exp_r);
  endtask

  initial begin
    int ra, rb;
    bit done_in_reset;

    // Reset
    #12;
    chk("reset_q", 32'(Q), 0);
    chk("reset_r", 32'(R), 0);
    chk("reset_busy", 32'(busy), 0);
    chk("reset_done", 32'(done), 0);
    chk("reset_dbz", 32'(div_by_zero), 0);
    chk("reset_state", 32'(dbg_state), 32'(IDLE));
    @(negedge clk);
    rst_n = 1'b1;

    // Directed cases
    run_div(13, 4, 0, 0, 0);
    run_div(15, 15, 0, 0, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("idle_hold_q", 32'(Q), 1);
    run_div(0, 7, 0, 0, 0);
    run_div(5, 9, 0, 0, 0);
    run_div(9, 0, 0, 0, 0);
    run_div(7, 2, 0, 0, 0);
    run_div(11, 1, 0, 0, 0);

    // Start held through RUN/DONE: one result, then held request taken in IDLE
    run_div(12, 5, 1, 1, 1);
    run_div(1, 1, 0, 0, 0);

    // Asynchronous reset in the middle of RUN
    @(negedge clk);
    A = 4'd13;
    B = 4'd4;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_q", 32'(Q), 0);
    chk("rst_mid_r", 32'(R), 0);
    chk("rst_mid_busy", 32'(busy), 0);
    chk("rst_mid_done", 32'(done), 0);
    chk("rst_mid_state", 32'(dbg_state), 32'(IDLE));
    done_in_reset = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) done_in_reset = 1;
      if (i == 3) begin
        @(negedge clk);
        rst_n = 1'b1;
      end
    end
    chk("no_done_after_abort", 32'(done_in_reset), 0);
    run_div(14, 3, 0, 0, 0);

    // Exhaustive sweep, random idle gaps between requests
    for (int a = 0; a <= MAXV; a++) begin
      for (int b = 1; b <= MAXV; b++) begin
        repeat ($urandom_range(0, 2)) @(posedge clk);
        run_div(a, b, 0, 0, 0);
      end
    end

    // Random pairs, divide-by-zero included
    for (int i = 0; i < 40; i++) begin
      ra = $urandom_range(0, MAXV);
      rb = ($urandom_range(0, 4) == 0) ? 0 : $urandom_range(0, MAXV);
      run_div(ra, rb, 0, 0, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
